// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - decode/ALU/load arbiter for a 1W-or-2R register file with zero-fill.
// Optional REGFILE_R0_ZERO_EN: r0 reads as zero and writes to r0 are acknowledged but dropped.
module regfile_port_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        wb0_req,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_req,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  output logic        rf_rw,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  output logic [31:0] rf_in_reg,
  input  logic [31:0] rf_out_a,
  input  logic [31:0] rf_out_b,
  output logic        init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t      state_q;
  logic [4:0]  init_cnt_q;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        rd_valid_q;
  logic        wb_any, rd_win, sel_wb1;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  assign wb_any  = wb0_req | wb1_req;
  assign rd_win  = rd_req && (!wb_any || (starve_cnt_q >= MAX_W));
  assign sel_wb1 = wb1_req && (!wb0_req || rr_ptr_q);

  always_comb begin
    rf_rw        = 1'b1;
    rf_addr_a    = 5'd0;
    rf_addr_b    = 5'd0;
    rf_in_reg    = 32'd0;
    rd_ready     = 1'b0;
    wb0_ready    = 1'b0;
    wb1_ready    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    win_addr     = sel_wb1 ? wb1_addr : wb0_addr;
    win_data     = sel_wb1 ? wb1_data : wb0_data;
    if (!rst_n) begin
      rf_rw = 1'b1;
    end else if (state_q == S_INIT) begin
      rf_rw     = 1'b0;
      rf_addr_a = init_cnt_q;
    end else if (rd_win) begin
      rf_addr_a    = rd_addr_a;
      rf_addr_b    = rd_addr_b;
      rd_ready     = 1'b1;
      starve_cnt_d = 4'd0;
    end else if (wb_any) begin
      wb0_ready = !sel_wb1;
      wb1_ready = sel_wb1;
      rr_ptr_d  = !sel_wb1;
      if (rd_req)
        starve_cnt_d = (starve_cnt_q >= MAX_W) ? MAX_W : 4'(starve_cnt_q + 4'd1);
`ifdef REGFILE_R0_ZERO_EN
      if (win_addr != 5'd0) begin
        rf_rw     = 1'b0;
        rf_addr_a = win_addr;
        rf_in_reg = win_data;
      end
`else
      rf_rw     = 1'b0;
      rf_addr_a = win_addr;
      rf_in_reg = win_data;
`endif
    end
  end

`ifdef REGFILE_R0_ZERO_EN
  logic rd_a_zero_q, rd_b_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_zero_q <= 1'b0;
      rd_b_zero_q <= 1'b0;
    end else if (rd_ready) begin
      rd_a_zero_q <= (rd_addr_a == 5'd0);
      rd_b_zero_q <= (rd_addr_b == 5'd0);
    end
  end

  assign rd_data_a = (rd_valid_q && !rd_a_zero_q) ? rf_out_a : 32'd0;
  assign rd_data_b = (rd_valid_q && !rd_b_zero_q) ? rf_out_b : 32'd0;
`else
  assign rd_data_a = rd_valid_q ? rf_out_a : 32'd0;
  assign rd_data_b = rd_valid_q ? rf_out_b : 32'd0;
`endif

  assign rd_valid  = rd_valid_q;
  assign init_done = rst_n && (state_q == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT_ZERO ? S_INIT : S_RUN;
      init_cnt_q   <= 5'd0;
      starve_cnt_q <= 4'd0;
      rr_ptr_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_ready;
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 5'd1;
          if (init_cnt_q == 5'd31)
            state_q <= S_RUN;
        end
        default: begin
          starve_cnt_q <= starve_cnt_d;
          rr_ptr_q     <= rr_ptr_d;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed bench for regfile_port_arbiter with a behavioural register file.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        rd_ready, rd_valid;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb0_req, wb1_req;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_rw;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_in_reg, rf_out_a, rf_out_b;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_port_arbiter #(.MAX_WAIT(4), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb0_req(wb0_req), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_req(wb1_req), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_rw(rf_rw), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_in_reg(rf_in_reg),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b), .init_done(init_done)
  );

  // Register file: garbage at power-up so only the zero-fill can clear it.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    rf_out_a = 32'd0;
    rf_out_b = 32'd0;
  end

  always @(posedge clk) begin
    if (!rf_rw) mem[rf_addr_a] <= rf_in_reg;
    rf_out_a <= mem[rf_addr_a];
    rf_out_b <= mem[rf_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] ea, input logic [31:0] eb);
    rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b;
    #1;
    check("rd_ready", 32'(rd_ready), 32'd1);
    check("rd_rf_addr", {22'd0, rf_rw, rf_addr_a, rf_addr_b}, {22'd0, 1'b1, a, b});
    tick;
    rd_req = 1'b0;
    #1;
    check("rd_valid", 32'(rd_valid), 32'd1);
    check("rd_data_a", rd_data_a, ea);
    check("rd_data_b", rd_data_b, eb);
    tick;
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
  endtask

  task automatic do_write(input bit sel1, input logic [4:0] a, input logic [31:0] d,
                          input logic exp_rw);
    if (sel1) begin wb1_req = 1'b1; wb1_addr = a; wb1_data = d; end
    else      begin wb0_req = 1'b1; wb0_addr = a; wb0_data = d; end
    #1;
    check("wr_ready", {30'd0, wb1_ready, wb0_ready}, sel1 ? 32'd2 : 32'd1);
    check("wr_rf_rw", 32'(rf_rw), 32'(exp_rw));
    if (!exp_rw) check("wr_rf_bus", {27'd0, rf_addr_a} ^ rf_in_reg, {27'd0, a} ^ d);
    tick;
    wb0_req = 1'b0; wb1_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    wb0_req = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
    wb1_req = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
    #2;
    check("rst_outputs", {26'd0, init_done, rd_valid, rf_rw, rd_ready, wb0_ready, wb1_ready},
          32'b001000);
    check("rst_rf_addr", {22'd0, rf_addr_a, rf_addr_b}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      check("init_sweep", {25'd0, init_done, rf_rw, rf_addr_a}, {25'd0, 1'b0, 1'b0, 5'(i)});
      tick;
    end
    check("init_done", 32'(init_done), 32'd1);
    do_read(5'd5, 5'd31, 32'd0, 32'd0);

    do_write(1'b0, 5'd3, 32'hDEADBEEF, 1'b0);
    do_read(5'd3, 5'd0, 32'hDEADBEEF, 32'd0);

    do_write(1'b1, 5'd7, 32'h0000_1234, 1'b0);
    wb0_req = 1'b1; wb0_addr = 5'd10; wb0_data = 32'hA0A0A0A0;
    wb1_req = 1'b1; wb1_addr = 5'd11; wb1_data = 32'hB1B1B1B1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", {30'd0, wb1_ready, wb0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick;
    end
    wb0_req = 1'b0; wb1_req = 1'b0;
    do_read(5'd10, 5'd11, 32'hA0A0A0A0, 32'hB1B1B1B1);

    rd_req = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd10;
    wb0_req = 1'b1; wb1_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("starve_rd", 32'(rd_ready), (k == 4) ? 32'd1 : 32'd0);
      check("starve_wb", {30'd0, wb1_ready, wb0_ready},
            (k == 4) ? 32'd0 : ((k % 2 == 0) ? 32'd1 : 32'd2));
      tick;
    end
    rd_req = 1'b0;
    #1;
    check("starve_valid", 32'(rd_valid), 32'd1);
    check("starve_data_a", rd_data_a, 32'hDEADBEEF);
    check("starve_data_b", rd_data_b, 32'hA0A0A0A0);
    check("wr_in_valid_cycle", 32'(wb0_ready), 32'd1);
    tick;
    rd_req = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd0;
    #1;
    check("starve_cleared", 32'(rd_ready), 32'd0);
    tick;
    wb0_req = 1'b0; wb1_req = 1'b0;
    #1;
    check("rd_after_wb", 32'(rd_ready), 32'd1);
    tick;
    rd_req = 1'b0;
    #1;
    check("rd_after_wb_data", rd_data_a, 32'hDEADBEEF);
    tick;

    rd_req = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
    tick;
    rd_req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 32'(rd_valid), 32'd0);
    check("rst_drop_data", rd_data_a, 32'd0);
    check("rst_rf_rw", 32'(rf_rw), 32'd1);
    tick;
    rst_n = 1'b1;
    #1;
    check("reinit_cnt0", {26'd0, rf_rw, rf_addr_a}, 32'd0);
    tick;
    check("reinit_cnt1", {26'd0, rf_rw, rf_addr_a}, 32'd1);
    for (int i = 0; i < 30; i++) tick;
    check("reinit_last", {25'd0, init_done, rf_rw, rf_addr_a}, {25'd0, 2'b00, 5'd31});
    tick;
    check("reinit_done", 32'(init_done), 32'd1);
    do_read(5'd3, 5'd7, 32'd0, 32'd0);

`ifdef REGFILE_R0_ZERO_EN
    do_write(1'b1, 5'd0, 32'h0000_1234, 1'b1);
    do_read(5'd0, 5'd0, 32'd0, 32'd0);
`else
    do_write(1'b1, 5'd0, 32'h0000_1234, 1'b0);
    do_read(5'd0, 5'd0, 32'h0000_1234, 32'h0000_1234);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
